// File: rtl/pipelined_subtractor_pkg.sv
// Shared constants, stage-count helper and stage-register layout for pipelined_subtractor.
// Sign-bit fields exist only when PIPELINED_SUBTRACTOR_OVF_EN is defined.
package sub_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   function automatic int stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Resolved low bits of d accumulate in d; a/b keep travelling for the high chunks.
   typedef struct packed {
      logic                 valid;
      logic [DEF_WIDTH-1:0] d;
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      logic                 borrow;
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
      logic                 sa;
      logic                 sb;
`endif
   } stage_t;

endpackage

// File: rtl/borrow_lookahead_chunk.sv
// Combinational CHUNK-wide subtractor slice: every internal borrow is a flat
// generate/propagate lookahead term, so there is no bit-to-bit ripple.
module borrow_lookahead_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             bin_i,
   output logic [CHUNK-1:0] d_o,
   output logic             bout_o
);

   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [CHUNK:0]   c;

   assign g = ~a_i & b_i;
   assign p = ~(a_i ^ b_i);

   always_comb begin
      logic acc;
      logic term;
      c = '0;
      for (int j = 0; j <= CHUNK; j++) begin
         term = bin_i;
         for (int i = 0; i < j; i++) term = term & p[i];
         acc = term;
         for (int i = 0; i < j; i++) begin
            term = g[i];
            for (int m = i + 1; m < j; m++) term = term & p[m];
            acc = acc | term;
         end
         c[j] = acc;
      end
   end

   assign d_o    = a_i ^ b_i ^ c[CHUNK-1:0];
   assign bout_o = c[CHUNK];

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined d = a - b - bin, one CHUNK of result bits resolved per stage, valid/ready at both ends.
// Define PIPELINED_SUBTRACTOR_OVF_EN to carry sign bits and produce the signed overflow flag.
module pipelined_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int STAGES = stages(WIDTH, CHUNK);

   // stage_t is laid out for the package width, so the datapath cannot be resized independently.
   if (WIDTH != DEF_WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("pipelined_subtractor: WIDTH must equal DEF_WIDTH and be a multiple of CHUNK");
   end

   stage_t                       st_q  [STAGES];
   stage_t                       st_d  [STAGES];
   stage_t                       src_s [STAGES];
   logic [STAGES-1:0][CHUNK-1:0] diff;
   logic [STAGES-1:0]            bo;
   logic [STAGES-1:0]            ld;

   always_comb begin
      src_s[0]        = '0;
      src_s[0].valid  = in_valid;
      src_s[0].a      = a;
      src_s[0].b      = b;
      src_s[0].borrow = bin;
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
      src_s[0].sa     = a[WIDTH-1];
      src_s[0].sb     = b[WIDTH-1];
`endif
      for (int k = 1; k < STAGES; k++) src_s[k] = st_q[k-1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      borrow_lookahead_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a_i    (src_s[k].a[k*CHUNK +: CHUNK]),
         .b_i    (src_s[k].b[k*CHUNK +: CHUNK]),
         .bin_i  (src_s[k].borrow),
         .d_o    (diff[k]),
         .bout_o (bo[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         st_d[k]                       = src_s[k];
         st_d[k].d[k*CHUNK +: CHUNK]   = diff[k];
         st_d[k].borrow                = bo[k];
      end
   end

   // A stage may load when it is empty or its occupant moves on; walked back from out_ready.
   always_comb begin
      logic go;
      ld = '0;
      go = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = ~st_q[k].valid | go;
         go    = ld[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) st_q[k] <= st_d[k];
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = st_q[STAGES-1].valid;
   assign d         = st_q[STAGES-1].d;
   assign bout      = st_q[STAGES-1].borrow;

`ifdef PIPELINED_SUBTRACTOR_OVF_EN
   assign ovf = (st_q[STAGES-1].sa ^ st_q[STAGES-1].sb) &
                (st_q[STAGES-1].d[WIDTH-1] ^ st_q[STAGES-1].sa);
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor: directed corner cases, backpressure, reset flush
// and a randomized stream, all checked against an arithmetic reference model.
module tb_pipelined_subtractor;

   localparam int W = 16;
   localparam int C = 4;
   localparam int S = W / C;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;

   always #5 clk = ~clk;

   pipelined_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf)
   );

   typedef struct {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   rnd_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
      exp_t   e;
      longint ua;
      longint ub;
      longint r;
      ua     = longint'(ta);
      ub     = longint'(tb_);
      r      = ua - ub - longint'(tbin);
      e.d    = r[W-1:0];
      e.bout = (ua < ub + longint'(tbin));
`ifdef PIPELINED_SUBTRACTOR_OVF_EN
      e.ovf  = (ta[W-1] != tb_[W-1]) && (e.d[W-1] != ta[W-1]);
`else
      e.ovf  = 1'b0;
`endif
      e.acc  = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   // Monitor: pops on every output transfer, and checks the output holds while stalled.
   logic [W-1:0] hold_d;
   logic         hold_b;
   logic         hold_o;
   bit           hold_v = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (out_valid && hold_v) begin
            chk("hold_d", d, hold_d);
            chk("hold_bout", bout, hold_b);
            chk("hold_ovf", ovf, hold_o);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("d", d, e.d);
               chk("bout", bout, e.bout);
               chk("ovf", ovf, e.ovf);
               if (e.lat) chk("latency", cyc - e.acc, S);
            end
            hold_v = 1'b0;
         end else if (out_valid) begin
            hold_v = 1'b1;
            hold_d = d;
            hold_b = bout;
            hold_o = ovf;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that transferred.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin, input bit lat);
      int   t;
      exp_t e;
      t        = 0;
      a        = ta;
      b        = tb_;
      bin      = tbin;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e     = model(ta, tb_, tbin);
            e.acc = cyc;
            e.lat = lat;
            sb_q.push_back(e);
            break;
         end
         t++;
         if (t > 300) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      chk("drain_remaining", sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      send(16'h1234, 16'h0234, 1'b0, 1'b1);
      drain();
      send(16'h0000, 16'h0001, 1'b0, 1'b1);
      drain();
      send(16'h8000, 16'h8000, 1'b1, 1'b1);
      send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      drain();
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
      send(16'h8000, 16'h7FFF, 1'b1, 1'b1);
      drain();

      // Backpressure: fill the pipe, stall, then release with more traffic pending.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(W'(16'h1111 * (i + 1)), W'(i * 3), i[0], 1'b0);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      fork
         begin
            send(16'h0005, 16'h0009, 1'b0, 1'b0);
            send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Random stream with random input gaps and output stalls.
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
            end
            rnd_on = 1'b0;
         end
      join
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset with transactions in flight: output drops at once and nothing stale follows.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(W'(16'h0F0F + i), W'(16'h0101), 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("inflight_out_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_d", d, 0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
